// File: rtl/prg_ray_rcv.sv
// Primary-ray receive buffer: reserves a slot per launched pixel, pairs rays in launch order (frame_done via PRG_RCV_FRAME_DONE_EN).
// Latency: captured ray visible at the head the cycle after ray_ready; frame_done one cycle after the final pop.
// Backpressure: credit admission via registered issue_ok; ds_stall holds the head stable, no ray is ever dropped.
`ifndef VGA_NUM_COLS
`define VGA_NUM_COLS 640
`endif
`ifndef VGA_NUM_ROWS
`define VGA_NUM_ROWS 480
`endif

package prg_ray_pkg;
    localparam int COLS = `VGA_NUM_COLS;
    localparam int ROWS = `VGA_NUM_ROWS;
    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vec3_t;

    typedef struct packed {
        vec3_t orig;
        vec3_t dir;
    } ray_vec_t;
endpackage

module prg_ray_rcv
    import prg_ray_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            v0,
    input  logic            issue_req,
    input  logic [XW-1:0]   pix_x,
    input  logic [YW-1:0]   pix_y,
    output logic            issue_ok,
    input  logic            ray_ready,
    input  ray_vec_t        prg_data,
    output logic            ray_valid,
    output ray_vec_t        ray_out,
    output logic [XW-1:0]   ray_x,
    output logic [YW-1:0]   ray_y,
    input  logic            ds_stall,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic            err,
    output logic            frame_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        ray_vec_t      ray;
        logic          filled;
    } entry_t;

    entry_t      entry_q [DEPTH];
    entry_t      entry_d [DEPTH];
    logic [AW:0] alloc_q, alloc_d;
    logic [AW:0] fill_q, fill_d;
    logic [AW:0] rd_q, rd_d;
    logic        issue_ok_q, issue_ok_d;
    logic        err_q, err_d;
    logic        launch, capture, orphan, pop;
    logic [AW:0] occ;

    assign ray_valid = (rd_q != fill_q);
    assign ray_out   = entry_q[rd_q[AW-1:0]].ray;
    assign ray_x     = entry_q[rd_q[AW-1:0]].x;
    assign ray_y     = entry_q[rd_q[AW-1:0]].y;
    assign occupancy = occ;
    assign issue_ok  = issue_ok_q;
    assign err       = err_q;

    always_comb begin
        occ     = alloc_q - rd_q;
        launch  = v0 & issue_req & issue_ok_q;
        capture = ray_ready & (fill_q != alloc_q);
        orphan  = ray_ready & (fill_q == alloc_q);
        pop     = ray_valid & ~ds_stall;

        entry_d = entry_q;
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;

        // The one-cycle lag on issue_ok is safe because launches are at most one per v0 rotation.
        if (launch) begin
            entry_d[alloc_q[AW-1:0]].x      = pix_x;
            entry_d[alloc_q[AW-1:0]].y      = pix_y;
            entry_d[alloc_q[AW-1:0]].filled = 1'b0;
            alloc_d = alloc_q + 1'b1;
        end
        if (capture) begin
            entry_d[fill_q[AW-1:0]].ray    = prg_data;
            entry_d[fill_q[AW-1:0]].filled = 1'b1;
            fill_d = fill_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end

        issue_ok_d = (occ < FULL_CNT);
        err_d      = err_q | orphan;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            alloc_q    <= '0;
            fill_q     <= '0;
            rd_q       <= '0;
            issue_ok_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            rd_q       <= rd_d;
            issue_ok_q <= issue_ok_d;
            err_q      <= err_d;
        end
    end

`ifdef PRG_RCV_FRAME_DONE_EN
    logic frame_done_q, frame_done_d;

    always_comb begin
        frame_done_d = pop & (ray_x == XW'(COLS - 1)) & (ray_y == YW'(ROWS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;
`else
    assign frame_done = 1'b0;
`endif

endmodule

// File: doc/prg_ray_rcv.md
# prg_ray_rcv

Receiving end of the primary-ray generator output. Reserves a buffer slot with the pixel coordinate at the moment a pixel is launched into the generator, then captures the `ray_vec_t` when `rayReady` fires, and delivers it in order to the downstream ray consumer. The generator has no stall input, so this block enforces credit-based admission to guarantee no ray is ever dropped. Sits between the primary ray generator and the traversal/intersection front end.

## Interface
- `DEPTH`, 8: slot count; power of two, at least 4.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `v0` in 1: phase strobe of the generator's 3-cycle rotation; a launch slot exists only when `v0`=1.
- `issue_req` in 1: the pixel scheduler wants to launch `pix_x`/`pix_y` in this slot.
- `pix_x` in $clog2(`VGA_NUM_COLS): column of the pixel being launched.
- `pix_y` in $clog2(`VGA_NUM_ROWS): row of the pixel being launched.
- `issue_ok` out 1: a slot is free; a launch is permitted.
- `ray_ready` in 1: the generator's `rayReady`.
- `prg_data` in ray_vec_t: the generator's ray; sampled only when `ray_ready`=1.
- `ray_valid` out 1: the head entry holds a captured ray.
- `ray_out` out ray_vec_t: the head ray.
- `ray_x`, `ray_y` out (as `pix_x`/`pix_y`): pixel of the head ray.
- `ds_stall` in 1: downstream cannot accept.
- `occupancy` out $clog2(DEPTH)+1: number of allocated slots.
- `err` out 1: sticky protocol error.
- `frame_done` out 1: end-of-frame pulse (see Configuration).

## Operation
- Circular array of DEPTH entries. Each entry holds {pix_x, pix_y, ray, filled}.
- Three pointers, each $clog2(DEPTH)+1 bits with a wrap bit:
  - `alloc_ptr`: next slot to reserve.
  - `fill_ptr`: next slot to receive a ray.
  - `rd_ptr`: head of the array.
- Launch: `launch = v0 & issue_req & issue_ok`.
  - Writes the coordinate into `alloc_ptr`, clears that slot's filled bit, and increments `alloc_ptr`.
  - `issue_req` without `v0`, or without `issue_ok`, is ignored; no state change.
- Capture: when `ray_ready`=1 and `fill_ptr`≠`alloc_ptr`, write `prg_data` into the `fill_ptr` slot, set its filled bit, and increment `fill_ptr`.
  - Rays therefore pair with coordinates strictly in launch order.
- Pop: `pop = ray_valid & ~ds_stall`. Increments `rd_ptr`.
- Output signals:
  - `ray_valid` = (`rd_ptr`≠`fill_ptr`).
  - `ray_out`, `ray_x`, `ray_y` come from the `rd_ptr` slot; they are held stable while `ray_valid` & `ds_stall`.
  - `occupancy` = `alloc_ptr` − `rd_ptr`.
  - `issue_ok` = registered (`occupancy` < DEPTH).
- Boundary conditions:
  - Full: `occupancy`=DEPTH drives `issue_ok`=0. A pop in that cycle raises `issue_ok` the next cycle, not combinationally.
  - Empty: `ray_valid`=0; `ds_stall` has no effect.
  - Launch, capture and pop in the same cycle are all honoured; each pointer moves independently.
  - Orphan ray: `ray_ready` with `fill_ptr`=`alloc_ptr` sets `err`=1. The ray is discarded and no pointer changes. `err` clears only on reset.
  - Wrap: pointers wrap modulo 2·DEPTH; full/empty are distinguished by the wrap bit.
- Reset mid-operation clears all pointers, filled bits and `err`; in-flight rays are lost. The scheduler must restart the frame.

## Timing
- Output values while `rst_n`=0:
  - `issue_ok`=0, `ray_valid`=0, `occupancy`=0, `err`=0, `frame_done`=0.
  - `ray_out`/`ray_x`/`ray_y` are all-zeros.
- `issue_ok` rises on the first clock edge after `rst_n` deasserts.
- Capture latency: `ray_ready` at edge N gives `ray_valid`=1 after edge N, provided that slot is the head. Data reaches the output one cycle after capture.
- Pop at edge N exposes the next entry's data after edge N.
- A launch at edge N raises `occupancy` after edge N; `issue_ok` reflects it after edge N+1.
  - Consequence: at most one launch per `v0` rotation (3 cycles), so this one-cycle lag can never overfill the array.

## Configuration
- `PRG_RCV_FRAME_DONE_EN` defined:
  - `frame_done` pulses for exactly one cycle on the pop of the entry with `ray_x`=`VGA_NUM_COLS`−1 and `ray_y`=`VGA_NUM_ROWS`−1.
  - Adds a registered pulse, so the pulse occurs the cycle after that pop.
- Macro undefined: `frame_done` is tied to 0 and no comparison logic is built.

## Test plan
- Reset then single launch: launch (x=5,y=7), `ray_ready` 20 cycles later with dir.x=0x3F800000 -> `ray_valid` the next cycle with `ray_x`=5, `ray_y`=7, dir.x=0x3F800000; `occupancy` goes 1→0 after the pop.
- Fill with DEPTH=8: 8 launches on consecutive `v0` slots, no `ray_ready` -> `issue_ok`=0 after the 8th; further `issue_req` is ignored and `occupancy` stays 8.
- Backpressure: 3 rays captured with `ds_stall`=1 -> head data held stable; release `ds_stall` -> rays emitted in launch order on 3 consecutive cycles.
- Simultaneous launch, capture and pop with `occupancy`=4 -> `occupancy` becomes 4, `fill_ptr` and `rd_ptr` both advance, no `err`.
- Orphan `ray_ready` after reset -> `err`=1 and stays high; `ray_valid` stays 0.
- With `PRG_RCV_FRAME_DONE_EN` defined: pop pixel (639,479) on a 640×480 configuration -> `frame_done` is high for exactly 1 cycle, the cycle after the pop.
